// File: rtl/team_12_uart_pkg.sv
// Shared types and frame constants for the team_12 UART transmitter.
package team_12_uart_pkg;
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = DATA_BITS + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
endpackage

// File: rtl/team_12_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and synchronous flush.
module team_12_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!nrst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/team_12_uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; tx is registered and idles high.
module team_12_uart_tx
    import team_12_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          en,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          tx_oeb,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          tx_q, tx_n;
    logic          pop;
    logic          full, empty;
    logic [7:0]    head;
    logic          last;

    assign wr_ready = en & ~full;
    assign tx_oeb   = ~en;
    assign tx       = tx_q;
    assign busy     = (state != IDLE) | ~empty;
    assign last     = (baud == BAUD_LAST);

    team_12_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .flush (~en),
        .push  (wr_valid & wr_ready),
        .pop   (pop),
        .din   (wr_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_comb begin
        state_n = state;
        baud_n  = baud + 1'b1;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    state_n = START;
                end
            end
            START: begin
                if (last) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (last) begin
                    baud_n  = '0;
                    shift_n = shift >> 1;
                    if (bit_idx == BIT_LAST) state_n = STOP;
                    else                     bit_n   = bit_idx + 1'b1;
                end
            end
            STOP: begin
                if (last) begin
                    baud_n = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Line level is derived from where the FSM lands, so tx updates with the state.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst || !en) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            tx_q    <= tx_n;
        end
    end
endmodule

// File: tb/tb_team_12_uart_tx.sv
// Directed bench for team_12_uart_tx with a byte scoreboard fed by a serial-line decoder.
module tb_team_12_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       nrst, en, wr_valid, wr_ready, tx, tx_oeb, busy;
    logic [7:0] wr_data;
    logic [3:0] fifo_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];

    team_12_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .nrst(nrst), .en(en), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .tx(tx), .tx_oeb(tx_oeb), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int j);
        int s;
        s = j / CPB;
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return b[s-1];
    endfunction

    task automatic write_byte(input logic [7:0] d);
        int n;
        n = 0;
        wr_data  = d;
        wr_valid = 1'b1;
        while (wr_ready !== 1'b1 && n < 200) begin tick(); n++; end
        if (wr_ready === 1'b1) begin
            sb.push_back(d);
            tick();
        end else chk("write_timeout", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin tick(); n++; end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
        repeat (3) tick();
    endtask

    // Serial decoder: samples bit centres, pops the scoreboard at each stop bit.
    initial begin
        int pos;
        logic [7:0] rx;
        logic [7:0] e;
        pos = -1;
        rx  = '0;
        forever begin
            @(negedge clk);
            if (nrst !== 1'b1 || en !== 1'b1) pos = -1;
            else if (pos < 0) begin
                if (tx === 1'b0) pos = 0;
            end else pos++;
            if (pos >= 0) begin
                if (pos == CPB/2) chk("rx_start", {31'd0, tx}, 32'd0);
                else if (pos >= CPB + CPB/2 && pos < 9*CPB && ((pos - CPB/2) % CPB) == 0)
                    rx[(pos - CPB/2)/CPB - 1] = tx;
                else if (pos == 9*CPB + CPB/2) begin
                    chk("rx_stop", {31'd0, tx}, 32'd1);
                    chk("rx_expected", {31'd0, sb.size() > 0}, 32'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("rx_byte", {24'd0, rx}, {24'd0, e});
                    end
                end
                if (pos == 10*CPB - 1) pos = -1;
            end
        end
    end

    initial begin
        logic [7:0] b0, b1;
        nrst = 1'b0; en = 1'b1; wr_valid = 1'b0; wr_data = '0;
        repeat (2) tick();
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {28'd0, fifo_count}, 32'd0);
        chk("rst_ready_en1", {31'd0, wr_ready}, 32'd1);
        chk("rst_oeb_en1", {31'd0, tx_oeb}, 32'd0);
        en = 1'b0; #1;
        chk("rst_ready_en0", {31'd0, wr_ready}, 32'd0);
        chk("rst_oeb_en0", {31'd0, tx_oeb}, 32'd1);
        en = 1'b1;
        tick();
        nrst = 1'b1;
        tick();

        // Single byte: exact waveform and latency.
        write_byte(8'hA5);
        chk("single_pre_tx", {31'd0, tx}, 32'd1);
        chk("single_pre_count", {28'd0, fifo_count}, 32'd1);
        tick();
        chk("single_count_popped", {28'd0, fifo_count}, 32'd0);
        for (int j = 0; j < 10*CPB; j++) begin
            chk($sformatf("single_tx_%0d", j), {31'd0, tx}, {31'd0, exp_bit(8'hA5, j)});
            if (j == 10*CPB - 1) chk("single_busy_last", {31'd0, busy}, 32'd1);
            if (j < 10*CPB - 1) tick();
        end
        tick();
        chk("single_busy_fall", {31'd0, busy}, 32'd0);
        chk("single_count_end", {28'd0, fifo_count}, 32'd0);
        repeat (3) tick();

        // Back-to-back frames with no gap.
        b0 = 8'h00; b1 = 8'hFF;
        write_byte(b0);
        write_byte(b1);
        chk("b2b_count", {28'd0, fifo_count}, 32'd1);
        for (int j = 0; j < 20*CPB; j++) begin
            chk($sformatf("b2b_tx_%0d", j), {31'd0, tx},
                {31'd0, (j < 10*CPB) ? exp_bit(b0, j) : exp_bit(b1, j - 10*CPB)});
            tick();
        end
        chk("b2b_busy_fall", {31'd0, busy}, 32'd0);
        repeat (3) tick();

        // FIFO full, then a tenth byte that must stall until a slot frees.
        for (int i = 0; i < 9; i++) write_byte(8'h10 + 8'(i));
        chk("full_count", {28'd0, fifo_count}, 32'd8);
        chk("full_ready", {31'd0, wr_ready}, 32'd0);
        write_byte(8'h99);
        wait_idle(800);

        // Simultaneous push and pop on the STOP->START edge.
        write_byte(8'h21);
        write_byte(8'h42);
        repeat (10*CPB - 1) tick();
        chk("pp_count_before", {28'd0, fifo_count}, 32'd1);
        write_byte(8'h63);
        chk("pp_count_after", {28'd0, fifo_count}, 32'd1);
        chk("pp_tx_start", {31'd0, tx}, 32'd0);
        wait_idle(300);

        // Enable abort mid-DATA with three bytes queued.
        for (int i = 0; i < 4; i++) write_byte(8'hC0 + 8'(i));
        repeat (8) tick();
        chk("abort_queued", {28'd0, fifo_count}, 32'd3);
        en = 1'b0;
        sb.delete();
        tick();
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_oeb", {31'd0, tx_oeb}, 32'd1);
        chk("abort_count", {28'd0, fifo_count}, 32'd0);
        chk("abort_ready", {31'd0, wr_ready}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        tick();
        en = 1'b1;
        tick();
        write_byte(8'h3C);
        tick();
        chk("abort_resume_tx", {31'd0, tx}, 32'd0);
        wait_idle(300);

        // Reset during the start bit.
        write_byte(8'h5A);
        repeat (2) tick();
        nrst = 1'b0;
        sb.delete();
        tick();
        chk("mrst_tx", {31'd0, tx}, 32'd1);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_count", {28'd0, fifo_count}, 32'd0);
        nrst = 1'b1;
        repeat (5) tick();
        chk("mrst_tx_quiet", {31'd0, tx}, 32'd1);

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
